// File: rtl/algo_stream_sum.sv
// Avalon-ST packet stage: forwards header and data words with backpressure, accumulates the
// per-sample sum and index-weighted sum of the data section, and appends them as trailer words.
module algo_stream_sum #(
   parameter int HEADER_WORDS = 3,
   parameter int DATA_WORDS   = 160,
   parameter int SAMPLE_W     = 16,
   parameter int ENABLE_WSUM  = 1
) (
   input  logic        clk_clk,
   input  logic        rst_reset_n,
   input  logic [31:0] data_in_data,
   input  logic        data_in_valid,
   output logic        data_in_ready,
   input  logic        data_in_startofpacket,
   input  logic        data_in_endofpacket,
   input  logic [1:0]  data_in_empty,
   output logic [31:0] data_out_data,
   output logic        data_out_valid,
   input  logic        data_out_ready,
   output logic        data_out_startofpacket,
   output logic        data_out_endofpacket,
   output logic [1:0]  data_out_empty,
   output logic        err_short,
   output logic        err_long,
   output logic        pkt_done
);

   localparam int          LANES     = 32 / SAMPLE_W;
   localparam logic [15:0] HDR_WC    = 16'(HEADER_WORDS);
   localparam logic [15:0] HDR_LAST  = 16'(HEADER_WORDS - 1);
   localparam logic [15:0] LAST_WC   = 16'(HEADER_WORDS + DATA_WORDS - 1);
   localparam logic [32:0] MASK_FULL = (33'd1 << SAMPLE_W) - 33'd1;
   localparam logic [31:0] LANE_MASK = MASK_FULL[31:0];
   localparam logic        TI_LAST   = (ENABLE_WSUM != 0) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {IDLE, HDR, DATA, CALC, TRAIL, DRAIN} state_t;

   state_t      state, state_nx;
   logic [15:0] wc;
   logic        ti;
   logic [31:0] sum, wsum;
   logic        long_flag;

   logic        in_ready_c, out_valid_c, sop_c, eop_c;
   logic [31:0] out_data_c;
   logic        in_xfer, out_xfer;
   logic        short_nx, long_nx, done_nx;
   logic [31:0] word_sum, word_wsum, base_n, lane_val;
   logic        unused_empty;

   function automatic logic [31:0] lane_of(input logic [31:0] w, input int l);
      return (w >> (l * SAMPLE_W)) & LANE_MASK;
   endfunction

   // Contribution of the current data word; sample index n = data word index * LANES + lane.
   always_comb begin
      word_sum  = '0;
      word_wsum = '0;
      lane_val  = '0;
      base_n    = 32'(wc - HDR_WC) * 32'(LANES);
      for (int l = 0; l < LANES; l++) begin
         lane_val  = lane_of(data_in_data, l);
         word_sum  = word_sum + lane_val;
         word_wsum = word_wsum + (base_n + 32'(l)) * lane_val;
      end
   end

   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      out_data_c  = data_in_data;
      sop_c       = 1'b0;
      eop_c       = 1'b0;
      state_nx    = state;
      short_nx    = 1'b0;
      long_nx     = 1'b0;
      done_nx     = 1'b0;

      case (state)
         IDLE: begin
            if (data_in_valid && data_in_startofpacket) begin
               in_ready_c  = data_out_ready;
               out_valid_c = 1'b1;
               sop_c       = 1'b1;
            end else begin
               in_ready_c  = 1'b1;
            end
         end
         HDR, DATA: begin
            in_ready_c  = data_out_ready;
            out_valid_c = data_in_valid;
         end
         TRAIL: begin
            out_valid_c = 1'b1;
            out_data_c  = (ti && (ENABLE_WSUM != 0)) ? wsum : sum;
            eop_c       = (ti == TI_LAST);
         end
         DRAIN:   in_ready_c = 1'b1;
         default: ;
      endcase

      in_xfer  = data_in_valid & in_ready_c;
      out_xfer = out_valid_c & data_out_ready;

      case (state)
         IDLE: begin
            if (in_xfer && data_in_startofpacket)
               state_nx = (HEADER_WORDS > 1) ? HDR : DATA;
         end
         HDR: begin
            if (in_xfer) begin
               if (data_in_endofpacket) begin
                  state_nx = CALC;
                  short_nx = 1'b1;
               end else if (wc == HDR_LAST) begin
                  state_nx = DATA;
               end
            end
         end
         DATA: begin
            if (in_xfer) begin
               if (wc == LAST_WC) begin
                  state_nx = CALC;
               end else if (data_in_endofpacket) begin
                  state_nx = CALC;
                  short_nx = 1'b1;
               end
            end
         end
         CALC: state_nx = TRAIL;
         TRAIL: begin
            if (out_xfer && (ti == TI_LAST)) begin
               done_nx = 1'b1;
               if (long_flag) begin
                  state_nx = DRAIN;
                  long_nx  = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         DRAIN: begin
            if (in_xfer && data_in_endofpacket)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge rst_reset_n) begin
      if (!rst_reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk_clk or negedge rst_reset_n) begin
      if (!rst_reset_n) begin
         wc        <= '0;
         ti        <= 1'b0;
         sum       <= '0;
         wsum      <= '0;
         long_flag <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
         pkt_done  <= 1'b0;
      end else begin
         err_short <= short_nx;
         err_long  <= long_nx;
         pkt_done  <= done_nx;
         case (state)
            IDLE: begin
               if (in_xfer && data_in_startofpacket) begin
                  wc        <= 16'd1;
                  sum       <= '0;
                  wsum      <= '0;
                  long_flag <= 1'b0;
               end
            end
            HDR: begin
               if (in_xfer)
                  wc <= wc + 16'd1;
            end
            DATA: begin
               if (in_xfer) begin
                  wc   <= wc + 16'd1;
                  sum  <= sum + word_sum;
                  wsum <= wsum + word_wsum;
                  if ((wc == LAST_WC) && !data_in_endofpacket)
                     long_flag <= 1'b1;
               end
            end
            CALC: ti <= 1'b0;
            TRAIL: begin
               if (out_xfer)
                  ti <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Every output reads as zero while reset is held, regardless of the input handshake.
   assign data_in_ready          = rst_reset_n & in_ready_c;
   assign data_out_valid         = rst_reset_n & out_valid_c;
   assign data_out_data          = rst_reset_n ? out_data_c : 32'd0;
   assign data_out_startofpacket = rst_reset_n & sop_c;
   assign data_out_endofpacket   = rst_reset_n & eop_c;
   assign data_out_empty         = 2'b00;
   assign unused_empty           = ^data_in_empty;

endmodule

// File: tb/tb_algo_stream_sum.sv
// Randomized bench for algo_stream_sum: packets are scored against a list-level model that
// derives forwarded words, trailer sums and error pulses directly from each packet's contents.
module tb_algo_stream_sum;

   localparam int HW    = 3;
   localparam int DW    = 160;
   localparam int SW    = 16;
   localparam int LANES = 32 / SW;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_in_data = '0;
   logic        data_in_valid = 1'b0;
   logic        data_in_ready;
   logic        data_in_startofpacket = 1'b0;
   logic        data_in_endofpacket = 1'b0;
   logic [1:0]  data_in_empty = 2'b00;
   logic [31:0] data_out_data;
   logic        data_out_valid;
   logic        data_out_ready = 1'b1;
   logic        data_out_startofpacket;
   logic        data_out_endofpacket;
   logic [1:0]  data_out_empty;
   logic        err_short, err_long, pkt_done;

   algo_stream_sum #(.HEADER_WORDS(HW), .DATA_WORDS(DW), .SAMPLE_W(SW), .ENABLE_WSUM(1)) dut (
      .clk_clk               (clk),
      .rst_reset_n           (rst_n),
      .data_in_data          (data_in_data),
      .data_in_valid         (data_in_valid),
      .data_in_ready         (data_in_ready),
      .data_in_startofpacket (data_in_startofpacket),
      .data_in_endofpacket   (data_in_endofpacket),
      .data_in_empty         (data_in_empty),
      .data_out_data         (data_out_data),
      .data_out_valid        (data_out_valid),
      .data_out_ready        (data_out_ready),
      .data_out_startofpacket(data_out_startofpacket),
      .data_out_endofpacket  (data_out_endofpacket),
      .data_out_empty        (data_out_empty),
      .err_short             (err_short),
      .err_long              (err_long),
      .pkt_done              (pkt_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output-ready pattern: 0 always ready, 1 ready one cycle in three, 2 random.
   int or_mode = 0;
   int cyc = 0;
   always @(posedge clk) begin
      #1;
      cyc++;
      case (or_mode)
         1:       data_out_ready = (cyc % 3 == 0);
         2:       data_out_ready = ($urandom_range(0, 2) != 0);
         default: data_out_ready = 1'b1;
      endcase
   end

   logic [33:0] got_q[$];
   int short_cnt = 0;
   int long_cnt = 0;
   int done_cnt = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (data_out_valid && data_out_ready)
            got_q.push_back({data_out_startofpacket, data_out_endofpacket, data_out_data});
         short_cnt += int'(err_short);
         long_cnt  += int'(err_long);
         done_cnt  += int'(pkt_done);
      end
   end

   logic [33:0] exp_q[$];
   int exp_short = 0;
   int exp_long = 0;
   int exp_done = 0;
   int rd = 0;
   bit gap_en = 0;

   task automatic send_word(input logic [31:0] d, input logic sop, input logic eop,
                            input logic pass, input logic first);
      logic acc;
      int   n;
      if (gap_en && $urandom_range(0, 3) == 0) begin
         data_in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      data_in_data          = d;
      data_in_startofpacket = sop;
      data_in_endofpacket   = eop;
      data_in_valid         = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 2000) begin
         @(negedge clk);
         acc = data_in_ready;
         if (pass && !first)
            chk_eq("rdy_mirror", 64'(data_in_ready), 64'(data_out_ready));
         if (acc && pass)
            chk_eq("pass_word", {29'd0, data_out_valid, data_out_startofpacket,
                                 data_out_endofpacket, data_out_data},
                   {29'd0, 1'b1, first, 1'b0, d});
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc)
         chk_eq("in_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk_eq(tag, {25'd0, data_in_ready, data_out_valid, data_out_startofpacket,
                   data_out_endofpacket, err_short, err_long, pkt_done, data_out_data}, 64'd0);
   endtask

   // kind 0: header 0xA,0xB,0xC and data 0x00010001; kind 1: random words.
   // abort_at >= 0: reset is applied after that many data words have been sent.
   task automatic run_pkt(input int ndata, input int kind, input int abort_at);
      logic [31:0] w[$];
      logic [31:0] s, sum, wsum;
      int total, nout, nsend;
      total = HW + ndata;
      for (int i = 0; i < total; i++) begin
         if (kind == 0) w.push_back((i < HW) ? 32'(10 + i) : 32'h0001_0001);
         else           w.push_back($urandom);
      end
      if (abort_at >= 0) nout = HW + abort_at;
      else               nout = (total < HW + DW) ? total : HW + DW;
      sum = 0;
      wsum = 0;
      for (int j = 0; j < nout - HW; j++)
         for (int l = 0; l < LANES; l++) begin
            s    = (w[HW + j] >> (l * SW)) & 32'h0000_FFFF;
            sum  = sum + s;
            wsum = wsum + 32'(j * LANES + l) * s;
         end
      for (int i = 0; i < nout; i++)
         exp_q.push_back({(i == 0), 1'b0, w[i]});
      if (abort_at < 0) begin
         exp_q.push_back({2'b00, sum});
         exp_q.push_back({2'b01, wsum});
         exp_done++;
         if (ndata < DW) exp_short++;
         if (ndata > DW) exp_long++;
      end
      nsend = (abort_at >= 0) ? nout : total;
      for (int i = 0; i < nsend; i++)
         send_word(w[i], (i == 0), (i == total - 1), (i < nout), (i == 0));
      if (abort_at >= 0) begin
         data_in_valid = 1'b1;
         data_in_startofpacket = 1'b1;
         rst_n = 1'b0;
         check_reset_outputs("rst_midpkt_a");
         @(posedge clk);
         check_reset_outputs("rst_midpkt_b");
         @(posedge clk);
         #1;
         rst_n = 1'b1;
      end
      data_in_valid = 1'b0;
      data_in_startofpacket = 1'b0;
      data_in_endofpacket = 1'b0;
   endtask

   task automatic settle(input string tag);
      int k;
      k = 0;
      while (got_q.size() < exp_q.size() && k < 3000) begin
         @(posedge clk);
         k++;
      end
      if (k >= 3000)
         chk_eq({tag, "_out_timeout"}, 64'd0, 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk_eq({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = rd; i < exp_q.size(); i++)
         if (i < got_q.size())
            chk_eq({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
      rd = exp_q.size();
      chk_eq({tag, "_err_short"}, 64'(short_cnt), 64'(exp_short));
      chk_eq({tag, "_err_long"}, 64'(long_cnt), 64'(exp_long));
      chk_eq({tag, "_pkt_done"}, 64'(done_cnt), 64'(exp_done));
   endtask

   task automatic chk_trailer(input string tag, input logic [31:0] esum, input logic [31:0] ewsum);
      int n;
      n = got_q.size();
      if (n >= 2) begin
         chk_eq({tag, "_sum"}, 64'(got_q[n - 2]), {30'd0, 2'b00, esum});
         chk_eq({tag, "_wsum"}, 64'(got_q[n - 1]), {30'd0, 2'b01, ewsum});
      end else begin
         chk_eq({tag, "_trailer_missing"}, 64'(n), 64'd2);
      end
   endtask

   initial begin
      data_in_valid = 1'b1;
      data_in_startofpacket = 1'b1;
      repeat (2) @(posedge clk);
      check_reset_outputs("rst_initial");
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      data_in_startofpacket = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_pkt(DW, 0, -1);
      settle("basic");
      chk_trailer("basic", 32'd320, 32'd51040);

      or_mode = 1;
      run_pkt(DW, 0, -1);
      settle("bp_1of3");
      chk_trailer("bp_1of3", 32'd320, 32'd51040);
      or_mode = 0;

      run_pkt(10, 0, -1);
      settle("short");
      chk_trailer("short", 32'd20, 32'd190);

      run_pkt(DW + 5, 1, -1);
      run_pkt(DW, 1, -1);
      settle("long");

      for (int i = 0; i < 3; i++)
         send_word($urandom & 32'hFFFF_FFF0, 1'b0, (i == 2), 1'b0, 1'b0);
      run_pkt(DW, 1, -1);
      settle("junk");

      run_pkt(DW, 0, 50);
      settle("abort");
      run_pkt(DW, 0, -1);
      settle("after_abort");
      chk_trailer("after_abort", 32'd320, 32'd51040);

      or_mode = 2;
      gap_en = 1;
      repeat (8) run_pkt($urandom_range(1, DW + 10), 1, -1);
      settle("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
